mc_controller: RTL and testbench
================================

// Module: mc_controller
// PURPOSE
//  Multicycle control FSM for the MIPS datapath (one shared memory, IR/ALUOut/MDR registers).
//  Sequences lw, sw, R-type (add/sub/and/or/slt), beq, addi, j over 3-5 cycles each.
//  Drives every datapath mux/enable; sits inside mips alongside the datapath, fed by IR[31:26]/[5:0].
// PARAMETERS
//  ILLEGAL_TRAP  0  0: unknown opcode in DECODE -> FETCH (instr skipped); 1: -> HALT until reset
// PORTS
//  clk         in   1  system clock, all state updates on rising edge
//  reset       in   1  synchronous, active-high
//  op          in   6  opcode, IR[31:26]
//  funct       in   6  function field, IR[5:0]
//  zero        in   1  ALU zero flag (combinational, same cycle)
//  pcen        out  1  PC register enable = pcwrite | (branch & zero)
//  memwrite    out  1  shared-memory write strobe
//  irwrite     out  1  instruction register load
//  regwrite    out  1  register file write
//  iord        out  1  memory addr mux: 0=PC, 1=ALUOut
//  regdst      out  1  write reg: 0=rt, 1=rd
//  memtoreg    out  1  write data: 0=ALUOut, 1=MDR
//  alusrca     out  1  ALU A: 0=PC, 1=rs data
//  alusrcb     out  2  ALU B: 00=rt data, 01=4, 10=signimm, 11=signimm<<2
//  pcsrc       out  2  next PC: 00=ALU result, 01=ALUOut, 10=jump target
//  alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
//  instr_done  out  1  high in final state of every completed instruction
//  illegal     out  1  high while in HALT (ILLEGAL_TRAP=1 only; else constant 0)
//  state       out  4  current state encoding (debug/verification)
// BEHAVIOUR
//  - Clock/reset: one clock; reset is synchronous and active-high. On reset edge state<=FETCH.
//  - Moore outputs decoded from registered state; pcen also uses zero. All unlisted outputs 0.
//  - While reset==1: pcen, irwrite, memwrite, regwrite forced 0 (gated); others per FETCH.
//  - States/encoding and asserted outputs (aluop: 00 add, 01 sub, 10 funct):
//    0 FETCH    iord=0 alusrca=0 alusrcb=01 aluop=00 pcsrc=00 irwrite=1 pcwrite=1 -> DECODE
//    1 DECODE   alusrca=0 alusrcb=11 aluop=00; op: lw/sw->MEMADR, R->EXECUTE, beq->BRANCH,
//               addi->ADDIEX, j->JUMP, other->FETCH or HALT per ILLEGAL_TRAP
//    2 MEMADR   alusrca=1 alusrcb=10 aluop=00; lw(100011)->MEMRD, sw(101011)->MEMWR
//    3 MEMRD    iord=1 -> MEMWB
//    4 MEMWB    regdst=0 memtoreg=1 regwrite=1 instr_done=1 -> FETCH
//    5 MEMWR    iord=1 memwrite=1 instr_done=1 -> FETCH
//    6 EXECUTE  alusrca=1 alusrcb=00 aluop=10 -> ALUWB
//    7 ALUWB    regdst=1 memtoreg=0 regwrite=1 instr_done=1 -> FETCH
//    8 BRANCH   alusrca=1 alusrcb=00 aluop=01 pcsrc=01 branch=1 instr_done=1 -> FETCH
//    9 ADDIEX   alusrca=1 alusrcb=10 aluop=00 -> ADDIWB
//   10 ADDIWB   regdst=0 memtoreg=0 regwrite=1 instr_done=1 -> FETCH
//   11 JUMP     pcsrc=10 pcwrite=1 instr_done=1 -> FETCH
//   12 HALT     illegal=1, all enables 0, self-loop; exit only via reset
//    13-15      unreachable; decode as HALT outputs, next state FETCH
//  - Opcodes: R 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
//  - Latency (cycles): lw 5, sw 4, R 4, addi 4, beq 3, j 3.
//  - aluop=10 funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; other -> 010.
//  - op/funct/zero sampled only in states above; IR stable after FETCH by construction.
//  - Reset mid-instruction: next edge -> FETCH, no partial write completes after reset edge.
// STRUCTURE
//  - mips_pkg: opcode, funct, state (4b) and aluop (2b) localparams; shared with datapath/bench.
//  - Sub-module mc_aludec: combinational aluop+funct -> alucontrol. FSM + output decode here.
// TESTING
//  - reset 1 for 22ns (10ns clk) -> state=0 each cycle, pcen/irwrite/memwrite/regwrite=0.
//  - lw (op 100011) -> states 0,1,2,3,4; regwrite+memtoreg in state 4; instr_done once.
//  - sw -> 0,1,2,5; memwrite=1, iord=1 only in state 5; alusrcb=10 in state 2.
//  - R sub (funct 100010) -> 0,1,6,7; alucontrol=110 in 6; slt gives 111; funct 000000 gives 010.
//  - beq zero=1 -> pcen=1 in state 8; zero=0 -> pcen=0; j -> pcsrc=10, pcen=1 in state 11.
//  - op 111111: ILLEGAL_TRAP=0 -> 0,1,0; =1 -> state 12, illegal=1 held; reset in state 6 -> 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS multicycle definitions: opcodes, funct codes, FSM states and ALU encodings.
// Also carries the decoded control bundle used inside the controller.
package mips_pkg;

    localparam int unsigned OP_W     = 6;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned STATE_W  = 4;
    localparam int unsigned ALUOP_W  = 2;
    localparam int unsigned ALUCTL_W = 3;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [ALUCTL_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALUCTL_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALUCTL_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALUCTL_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALUCTL_W-1:0] ALU_SLT = 3'b111;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_HALT    = 4'd12
    } state_e;

    // Moore control word decoded from the current state
    typedef struct packed {
        logic               pcwrite;
        logic               branch;
        logic               memwrite;
        logic               irwrite;
        logic               regwrite;
        logic               iord;
        logic               regdst;
        logic               memtoreg;
        logic               alusrca;
        logic [1:0]         alusrcb;
        logic [1:0]         pcsrc;
        logic [ALUOP_W-1:0] aluop;
        logic               instr_done;
        logic               halt;
    } ctrl_t;

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps the FSM's aluop class plus the R-type funct field to an ALU control code.
module mc_aludec
    import mips_pkg::*;
(
    input  logic [ALUOP_W-1:0]  aluop,
    input  logic [FUNCT_W-1:0]  funct,
    output logic [ALUCTL_W-1:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: sequences each instruction over 3-5 states and decodes
// every datapath mux select and enable from the registered state.
module mc_controller
    import mips_pkg::*;
#(
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OP_W-1:0]     op,
    input  logic [FUNCT_W-1:0]  funct,
    input  logic                zero,
    output logic                pcen,
    output logic                memwrite,
    output logic                irwrite,
    output logic                regwrite,
    output logic                iord,
    output logic                regdst,
    output logic                memtoreg,
    output logic                alusrca,
    output logic [1:0]          alusrcb,
    output logic [1:0]          pcsrc,
    output logic [ALUCTL_W-1:0] alucontrol,
    output logic                instr_done,
    output logic                illegal,
    output logic [STATE_W-1:0]  state
);

    state_e state_q;
    state_e state_d;
    state_e out_state;
    ctrl_t  ctrl;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore output decode; reset presents FETCH outputs immediately
    always_comb begin
        state_d   = S_FETCH;
        ctrl      = '0;
        out_state = reset ? S_FETCH : state_q;

        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = ILLEGAL_TRAP ? S_HALT : S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = S_MEMWB;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_FETCH;
        endcase

        case (out_state)
            S_FETCH: begin
                ctrl.irwrite = 1'b1;
                ctrl.pcwrite = 1'b1;
                ctrl.alusrcb = 2'b01;
            end
            S_DECODE: ctrl.alusrcb = 2'b11;
            S_MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = 2'b10;
            end
            S_MEMRD: ctrl.iord = 1'b1;
            S_MEMWB: begin
                ctrl.memtoreg   = 1'b1;
                ctrl.regwrite   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord       = 1'b1;
                ctrl.memwrite   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.regdst     = 1'b1;
                ctrl.regwrite   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alusrca    = 1'b1;
                ctrl.aluop      = ALUOP_SUB;
                ctrl.pcsrc      = 2'b01;
                ctrl.branch     = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = 2'b10;
            end
            S_ADDIWB: begin
                ctrl.regwrite   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_JUMP: begin
                ctrl.pcsrc      = 2'b10;
                ctrl.pcwrite    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl.halt = 1'b1;
        endcase
    end

    mc_aludec u_aludec (
        .aluop      (ctrl.aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

    // Architectural side effects are suppressed for the whole reset cycle
    assign pcen       = ~reset & (ctrl.pcwrite | (ctrl.branch & zero));
    assign memwrite   = ~reset & ctrl.memwrite;
    assign irwrite    = ~reset & ctrl.irwrite;
    assign regwrite   = ~reset & ctrl.regwrite;
    assign iord       = ctrl.iord;
    assign regdst     = ctrl.regdst;
    assign memtoreg   = ctrl.memtoreg;
    assign alusrca    = ctrl.alusrca;
    assign alusrcb    = ctrl.alusrcb;
    assign pcsrc      = ctrl.pcsrc;
    assign instr_done = ctrl.instr_done;
    assign illegal    = ILLEGAL_TRAP & ctrl.halt;
    assign state      = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed vector table, corner sequences
// (reset, illegal opcode, mid-instruction reset) and a randomized instruction stream.
module tb_mc_controller;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;

    logic       pcen0, memwrite0, irwrite0, regwrite0, iord0, regdst0, memtoreg0, alusrca0;
    logic [1:0] alusrcb0, pcsrc0;
    logic [2:0] alucontrol0;
    logic       instr_done0, illegal0;
    logic [3:0] state0;

    logic       pcen1, memwrite1, irwrite1, regwrite1, iord1, regdst1, memtoreg1, alusrca1;
    logic [1:0] alusrcb1, pcsrc1;
    logic [2:0] alucontrol1;
    logic       instr_done1, illegal1;
    logic [3:0] state1;

    mc_controller #(.ILLEGAL_TRAP(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pcen(pcen0), .memwrite(memwrite0), .irwrite(irwrite0), .regwrite(regwrite0),
        .iord(iord0), .regdst(regdst0), .memtoreg(memtoreg0), .alusrca(alusrca0),
        .alusrcb(alusrcb0), .pcsrc(pcsrc0), .alucontrol(alucontrol0),
        .instr_done(instr_done0), .illegal(illegal0), .state(state0)
    );

    mc_controller #(.ILLEGAL_TRAP(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pcen(pcen1), .memwrite(memwrite1), .irwrite(irwrite1), .regwrite(regwrite1),
        .iord(iord1), .regdst(regdst1), .memtoreg(memtoreg1), .alusrca(alusrca1),
        .alusrcb(alusrcb1), .pcsrc(pcsrc1), .alucontrol(alucontrol1),
        .instr_done(instr_done1), .illegal(illegal1), .state(state1)
    );

    logic [20:0] obs0, obs1;
    assign obs0 = {pcen0, memwrite0, irwrite0, regwrite0, iord0, regdst0, memtoreg0, alusrca0,
                   alusrcb0, pcsrc0, alucontrol0, instr_done0, illegal0, state0};
    assign obs1 = {pcen1, memwrite1, irwrite1, regwrite1, iord1, regdst1, memtoreg1, alusrca1,
                   alusrcb1, pcsrc1, alucontrol1, instr_done1, illegal1, state1};

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, settle, then sample
    task automatic step(input logic rst, input logic [5:0] o, input logic [5:0] f, input logic z);
        @(negedge clk);
        reset = rst;
        op    = o;
        funct = f;
        zero  = z;
        #1;
    endtask

    // After this, the next step() begins with the DUT in FETCH
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    function automatic logic [2:0] funct_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Reference output word for a state, laid out like obs0/obs1
    function automatic logic [20:0] exp_pack(input logic [3:0] s, input logic [5:0] fn,
                                             input logic z, input logic trap);
        logic       pw = 1'b0, br = 1'b0, mw = 1'b0, iw = 1'b0, rw = 1'b0;
        logic       io = 1'b0, rd = 1'b0, m2r = 1'b0, sa = 1'b0, dn = 1'b0, il = 1'b0;
        logic [1:0] sb = 2'b00, ps = 2'b00;
        logic [2:0] ac = 3'b010;
        case (s)
            4'd0:  begin iw = 1'b1; pw = 1'b1; sb = 2'b01; end
            4'd1:  sb = 2'b11;
            4'd2:  begin sa = 1'b1; sb = 2'b10; end
            4'd3:  io = 1'b1;
            4'd4:  begin m2r = 1'b1; rw = 1'b1; dn = 1'b1; end
            4'd5:  begin io = 1'b1; mw = 1'b1; dn = 1'b1; end
            4'd6:  begin sa = 1'b1; ac = funct_alu(fn); end
            4'd7:  begin rd = 1'b1; rw = 1'b1; dn = 1'b1; end
            4'd8:  begin sa = 1'b1; ac = 3'b110; ps = 2'b01; br = 1'b1; dn = 1'b1; end
            4'd9:  begin sa = 1'b1; sb = 2'b10; end
            4'd10: begin rw = 1'b1; dn = 1'b1; end
            4'd11: begin ps = 2'b10; pw = 1'b1; dn = 1'b1; end
            default: il = trap;
        endcase
        return {pw | (br & z), mw, iw, rw, io, rd, m2r, sa, sb, ps, ac, dn, il, s};
    endfunction

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        int         lat;
        logic [3:0] last;
        logic [2:0] alu2;
        logic       pcen_last;
    } vec_t;

    vec_t       vecs [12];
    logic [5:0] op_tab [6];
    logic [5:0] fn_tab [6];
    logic [3:0] exp_q [$];

    initial begin
        int         lat;
        logic [2:0] alu_s;
        logic [3:0] st_s;
        logic       pe_s;
        logic [5:0] r_op, r_fn;
        logic       r_z;
        logic [3:0] es;

        reset = 1'b1;
        op    = 6'd0;
        funct = 6'd0;
        zero  = 1'b1;

        // reset held 22ns: FETCH each cycle with architectural enables gated
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("rst%0d_state", i), 32'(state0), 32'd0);
            chk($sformatf("rst%0d_gated", i), 32'({pcen0, irwrite0, memwrite0, regwrite0}), 32'd0);
            chk($sformatf("rst%0d_fetchmux", i), 32'({iord0, alusrca0, alusrcb0, pcsrc0}), 32'b00100);
        end
        #1 reset = 1'b0;

        vecs[0]  = '{6'b100011, 6'b000000, 1'b0, 5, 4'd4,  3'b010, 1'b0};
        vecs[1]  = '{6'b101011, 6'b000000, 1'b0, 4, 4'd5,  3'b010, 1'b0};
        vecs[2]  = '{6'b000000, 6'b100010, 1'b0, 4, 4'd7,  3'b110, 1'b0};
        vecs[3]  = '{6'b000000, 6'b101010, 1'b1, 4, 4'd7,  3'b111, 1'b0};
        vecs[4]  = '{6'b000000, 6'b000000, 1'b0, 4, 4'd7,  3'b010, 1'b0};
        vecs[5]  = '{6'b000000, 6'b100100, 1'b0, 4, 4'd7,  3'b000, 1'b0};
        vecs[6]  = '{6'b000000, 6'b100101, 1'b0, 4, 4'd7,  3'b001, 1'b0};
        vecs[7]  = '{6'b000000, 6'b100000, 1'b0, 4, 4'd7,  3'b010, 1'b0};
        vecs[8]  = '{6'b000100, 6'b000000, 1'b1, 3, 4'd8,  3'b110, 1'b1};
        vecs[9]  = '{6'b000100, 6'b000000, 1'b0, 3, 4'd8,  3'b110, 1'b0};
        vecs[10] = '{6'b001000, 6'b000000, 1'b0, 4, 4'd10, 3'b010, 1'b0};
        vecs[11] = '{6'b000010, 6'b000000, 1'b0, 3, 4'd11, 3'b010, 1'b1};

        for (int i = 0; i < 12; i++) begin
            do_reset();
            lat   = 0;
            alu_s = 3'bxxx;
            st_s  = 4'bxxxx;
            pe_s  = 1'bx;
            for (int k = 0; k < 8; k++) begin
                step(1'b0, vecs[i].op, vecs[i].fn, vecs[i].z);
                if (k == 2) alu_s = alucontrol0;
                if (instr_done0) begin
                    lat  = k + 1;
                    st_s = state0;
                    pe_s = pcen0;
                    break;
                end
            end
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("vec%0d_last_state", i), 32'(st_s), 32'(vecs[i].last));
            chk($sformatf("vec%0d_alu", i), 32'(alu_s), 32'(vecs[i].alu2));
            chk($sformatf("vec%0d_pcen", i), 32'(pe_s), 32'(vecs[i].pcen_last));
        end

        // unknown opcode: skip without trap, hold HALT with trap
        do_reset();
        step(1'b0, 6'b111111, 6'd0, 1'b1);
        chk("ill_s0", 32'({state0, state1}), 32'h00);
        step(1'b0, 6'b111111, 6'd0, 1'b1);
        chk("ill_s1", 32'({state0, state1}), 32'h11);
        step(1'b0, 6'b111111, 6'd0, 1'b1);
        chk("ill_s2", 32'({state0, state1}), 32'h0c);
        chk("ill_flag2", 32'({illegal0, illegal1, instr_done1}), 32'b010);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 6'b100011, 6'd0, 1'b1);
            chk($sformatf("halt%0d_state", k), 32'(state1), 32'd12);
            chk($sformatf("halt%0d_out", k), 32'({illegal1, pcen1, irwrite1, memwrite1, regwrite1}), 32'b10000);
        end
        step(1'b1, 6'b100011, 6'd0, 1'b0);
        step(1'b0, 6'b100011, 6'd0, 1'b0);
        chk("halt_exit_state", 32'(state1), 32'd0);
        chk("halt_exit_illegal", 32'(illegal1), 32'd0);

        // reset arriving in EXECUTE must abandon the R-type writeback
        do_reset();
        step(1'b0, 6'b000000, 6'b100010, 1'b1);
        step(1'b0, 6'b000000, 6'b100010, 1'b1);
        step(1'b0, 6'b000000, 6'b100010, 1'b1);
        chk("midrst_exec", 32'(state0), 32'd6);
        step(1'b1, 6'b000000, 6'b100010, 1'b1);
        chk("midrst_gated", 32'({pcen0, irwrite0, memwrite0, regwrite0}), 32'd0);
        chk("midrst_fetchmux", 32'({alusrca0, alusrcb0, alucontrol0}), 32'b001010);
        step(1'b0, 6'b000000, 6'b100010, 1'b1);
        chk("midrst_fetch", 32'({state0, regwrite0}), 32'b00000);
        step(1'b0, 6'b000000, 6'b100010, 1'b1);
        chk("midrst_decode", 32'(state0), 32'd1);

        // randomized instruction stream against the state-sequence model
        op_tab = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
        fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
        do_reset();
        exp_q.delete();
        r_op = 6'd0;
        r_fn = 6'd0;
        for (int c = 0; c < 400; c++) begin
            if (exp_q.size() == 0) begin
                r_op = op_tab[$urandom_range(5)];
                r_fn = ($urandom_range(3) == 0) ? 6'($urandom) : fn_tab[$urandom_range(5)];
                exp_q.push_back(4'd0);
                exp_q.push_back(4'd1);
                case (r_op)
                    6'b100011: begin exp_q.push_back(4'd2); exp_q.push_back(4'd3); exp_q.push_back(4'd4); end
                    6'b101011: begin exp_q.push_back(4'd2); exp_q.push_back(4'd5); end
                    6'b000000: begin exp_q.push_back(4'd6); exp_q.push_back(4'd7); end
                    6'b000100: exp_q.push_back(4'd8);
                    6'b001000: begin exp_q.push_back(4'd9); exp_q.push_back(4'd10); end
                    default:   exp_q.push_back(4'd11);
                endcase
            end
            es  = exp_q.pop_front();
            r_z = 1'($urandom);
            step(1'b0, r_op, r_fn, r_z);
            chk($sformatf("rnd%0d_dut0", c), 32'(obs0), 32'(exp_pack(es, r_fn, r_z, 1'b0)));
            chk($sformatf("rnd%0d_dut1", c), 32'(obs1), 32'(exp_pack(es, r_fn, r_z, 1'b1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
